demux1x4_buf: RTL and testbench



---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_chan_buf.sv | 34 +++
 rtl/demux1x4_buf.sv | 65 ++++++
 tb/tb_demux1x4_buf.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1:4 buffered demultiplexer.
package demux_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] chan_idx_t;

    // Every data bit resets to this; the complemented copy resets to its inverse.
    localparam logic DATA_RST_BIT = 1'b0;

endpackage

// File: rtl/demux_chan_buf.sv
// Single-entry output buffer for one demux channel; keeps a true and a
// complemented copy of the stored word.
module demux_chan_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] data_n
);

    // wr_en can only be high while full if rd_ready is also high, so a
    // write always wins and covers the drain-and-refill case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            data   <= {WIDTH{DATA_RST_BIT}};
            data_n <= {WIDTH{~DATA_RST_BIT}};
        end else if (wr_en) begin
            valid  <= 1'b1;
            data   <= wr_data;
            data_n <= ~wr_data;
        end else if (rd_ready) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1x4_buf.sv
// 1:4 valid/ready demultiplexer with a registered one-word buffer per channel.
// Define DEMUX_ROUND_ROBIN_EN to ignore sel and rotate targets in strict order.
module demux1x4_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   sel,
    output logic [NCH-1:0]     out_valid,
    input  logic [NCH-1:0]     out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH*WIDTH-1:0] out_data_n
);

    chan_idx_t                  tgt;
    logic                       accept;
    logic [NCH-1:0]             wr_en;
    logic [NCH-1:0][WIDTH-1:0]  data_q;
    logic [NCH-1:0][WIDTH-1:0]  data_nq;

`ifdef DEMUX_ROUND_ROBIN_EN
    chan_idx_t rr_ptr;
    logic      sel_unused;

    assign sel_unused = ^sel;
    assign tgt        = rr_ptr;

    // Pointer only moves on accept, so a blocked channel stalls the rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= rr_ptr + chan_idx_t'(1);
    end
`else
    assign tgt = sel;
`endif

    assign in_ready = ~out_valid[tgt] | out_ready[tgt];
    assign accept   = in_valid & in_ready;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign wr_en[g] = accept & (tgt == chan_idx_t'(g));

        demux_chan_buf #(.WIDTH(WIDTH)) u_buf (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[g]),
            .wr_data  (in_data),
            .rd_ready (out_ready[g]),
            .valid    (out_valid[g]),
            .data     (data_q[g]),
            .data_n   (data_nq[g])
        );
    end

    assign out_data   = data_q;
    assign out_data_n = data_nq;

endmodule

// File: tb/tb_demux1x4_buf.sv
// Bench for demux1x4_buf: directed scenarios plus randomized traffic against
// a per-channel occupancy model.
module tb_demux1x4_buf;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [1:0]     sel;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [4*W-1:0] out_data;
    logic [4*W-1:0] out_data_n;

    always #5 clk = ~clk;

    demux1x4_buf #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_data_n (out_data_n)
    );

    int tests = 0;
    int fails = 0;

    // Model: which channels hold a word, what word, and the rotation position.
    bit           mv[4];
    logic [W-1:0] md[4];
    int           ptr;

    function automatic void mdl_clear();
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
        ptr = 0;
    endfunction

    function automatic int tgt();
`ifdef DEMUX_ROUND_ROBIN_EN
        return ptr;
`else
        return int'(sel);
`endif
    endfunction

    function automatic logic mdl_ready();
        int t = tgt();
        return !mv[t] || out_ready[t];
    endfunction

    function automatic logic [3:0] exp_valid();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = mv[i];
        return r;
    endfunction

    function automatic logic [4*W-1:0] exp_data();
        logic [4*W-1:0] r;
        for (int i = 0; i < 4; i++) r[i*W +: W] = md[i];
        return r;
    endfunction

    // Advance model and DUT by one rising edge; returns at the next falling edge.
    task automatic step();
        int t   = tgt();
        bit acc = in_valid && mdl_ready();
        for (int i = 0; i < 4; i++) begin
            if (acc && i == t) begin
                mv[i] = 1'b1;
                md[i] = in_data;
            end else if (out_ready[i]) begin
                mv[i] = 1'b0;
            end
        end
        if (acc) ptr = (ptr + 1) % 4;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (out_valid !== 4'b0000 || out_data !== '0 || out_data_n !== '1) begin
            fails++;
            $display("FAIL reset_init: valid=%b data=%h data_n=%h want 0000/0/all-ones", out_valid, out_data, out_data_n);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 4'b0000;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            in_data = W'(8'h80 + i);
            step();
        end
        in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 4'b1111 || out_data !== exp_data()) begin
            fails++;
            $display("FAIL fill_all: valid=%b data=%h want 1111 data=%h", out_valid, out_data, exp_data());
        end
        #2 rst = 1'b1;
        mdl_clear();
        #1;
        tests++;
        if (out_valid !== 4'b0000 || out_data !== '0 || out_data_n !== '1) begin
            fails++;
            $display("FAIL reset_async: valid=%b data=%h data_n=%h want 0000/0/all-ones", out_valid, out_data, out_data_n);
        end
        @(negedge clk);
        rst = 1'b0;
        sel = 2'd1;
        in_data = 8'h3C;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== exp_valid() || out_data !== exp_data() || out_data_n !== ~exp_data()) begin
            fails++;
            $display("FAIL reset_first_write: valid=%b data=%h want valid=%b data=%h", out_valid, out_data, exp_valid(), exp_data());
        end
    endtask

    task automatic test_routing();
        out_ready = 4'b1111;
        sel = 2'd2;
        in_data = 8'hA5;
        in_valid = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL route_ready: in_ready=%b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== exp_valid() || out_data !== exp_data() || out_data_n !== ~exp_data()) begin
            fails++;
            $display("FAIL route_model: valid=%b data=%h want valid=%b data=%h", out_valid, out_data, exp_valid(), exp_data());
        end
`ifndef DEMUX_ROUND_ROBIN_EN
        tests++;
        if (out_valid !== 4'b0100 || out_data[23:16] !== 8'hA5 || out_data_n[23:16] !== 8'h5A) begin
            fails++;
            $display("FAIL route_ch2: valid=%b d=%h dn=%h want 0100 a5 5a", out_valid, out_data[23:16], out_data_n[23:16]);
        end
`endif
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1111;
        step();
        out_ready = 4'b1101;
        sel = 2'd1;
        in_data = 8'h11;
        in_valid = 1'b1;
        step();
        in_data = 8'h22;
        #1;
        tests++;
        if (in_ready !== mdl_ready()) begin
            fails++;
            $display("FAIL bp_stall: in_ready=%b want %b", in_ready, mdl_ready());
        end
`ifndef DEMUX_ROUND_ROBIN_EN
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_stall_lit: in_ready=%b want 0", in_ready);
        end
`endif
        step();
        #1;
        tests++;
        if (in_ready !== mdl_ready() || out_data !== exp_data() || out_valid !== exp_valid()) begin
            fails++;
            $display("FAIL bp_hold: rdy=%b valid=%b data=%h want rdy=%b valid=%b data=%h", in_ready, out_valid, out_data, mdl_ready(), exp_valid(), exp_data());
        end
        out_ready = 4'b1111;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: in_ready=%b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== exp_valid() || out_data !== exp_data()) begin
            fails++;
            $display("FAIL bp_refill: valid=%b data=%h want valid=%b data=%h", out_valid, out_data, exp_valid(), exp_data());
        end
`ifndef DEMUX_ROUND_ROBIN_EN
        tests++;
        if (out_valid[1] !== 1'b1 || out_data[15:8] !== 8'h22) begin
            fails++;
            $display("FAIL bp_refill_lit: v1=%b d1=%h want 1 22", out_valid[1], out_data[15:8]);
        end
`endif
    endtask

    task automatic test_independence();
        out_ready = 4'b0000;
        step();
        sel = 2'd0;
        in_data = 8'h40;
        in_valid = 1'b1;
        step();
        sel = 2'd3;
        in_data = 8'h7E;
        #1;
        tests++;
        if (in_ready !== mdl_ready()) begin
            fails++;
            $display("FAIL indep_ready: in_ready=%b want %b", in_ready, mdl_ready());
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== exp_valid() || out_data !== exp_data()) begin
            fails++;
            $display("FAIL indep_model: valid=%b data=%h want valid=%b data=%h", out_valid, out_data, exp_valid(), exp_data());
        end
`ifndef DEMUX_ROUND_ROBIN_EN
        tests++;
        if (out_data[7:0] !== 8'h40 || out_data[31:24] !== 8'h7E || out_valid !== 4'b1011) begin
            fails++;
            $display("FAIL indep_lit: valid=%b d0=%h d3=%h want 1011 40 7e", out_valid, out_data[7:0], out_data[31:24]);
        end
`endif
    endtask

    task automatic test_simul_drain();
        out_ready = 4'b0110;
        step();
        out_ready = 4'b1001;
        step();
        out_ready = 4'b0000;
        tests++;
        if (out_valid !== exp_valid()) begin
            fails++;
            $display("FAIL drain_model: valid=%b want %b", out_valid, exp_valid());
        end
`ifndef DEMUX_ROUND_ROBIN_EN
        tests++;
        if (out_valid !== 4'b0000 || out_data[7:0] !== 8'h40) begin
            fails++;
            $display("FAIL drain_lit: valid=%b d0=%h want 0000 40", out_valid, out_data[7:0]);
        end
`endif
    endtask

`ifdef DEMUX_ROUND_ROBIN_EN
    task automatic test_round_robin();
        int ch;
        rst = 1'b1;
        mdl_clear();
        @(negedge clk);
        rst = 1'b0;
        sel = 2'd0;
        out_ready = 4'b1111;
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_data = W'(k);
            step();
            ch = (k - 1) % 4;
            tests++;
            if (out_valid[ch] !== 1'b1 || out_data[ch*W +: W] !== W'(k)) begin
                fails++;
                $display("FAIL rr_order: word %0d ch%0d valid=%b data=%h", k, ch, out_valid[ch], out_data[ch*W +: W]);
            end
        end
        rst = 1'b1;
        mdl_clear();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            in_data = W'(8'h10 * k);
            step();
        end
        out_ready = 4'b1101;
        in_data = 8'h50;
        step();
        in_data = 8'h60;
        for (int k = 0; k < 2; k++) begin
            #1;
            tests++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL rr_block: in_ready=%b want 0 (cycle %0d)", in_ready, k);
            end
            step();
        end
        out_ready = 4'b1111;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_data[15:8] !== 8'h60 || out_valid !== exp_valid()) begin
            fails++;
            $display("FAIL rr_resume: d1=%h valid=%b want 60 valid=%b", out_data[15:8], out_valid, exp_valid());
        end
    endtask
`endif

    task automatic test_random();
        bit hold = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = W'($urandom);
                sel      = 2'($urandom);
            end
            out_ready = 4'($urandom);
            #1;
            tests++;
            if (in_ready !== mdl_ready()) begin
                fails++;
                $display("FAIL rand_ready[%0d]: in_ready=%b want %b", n, in_ready, mdl_ready());
            end
            hold = in_valid && !mdl_ready();
            step();
            tests++;
            if (out_valid !== exp_valid() || out_data !== exp_data() || out_data_n !== ~exp_data()) begin
                fails++;
                $display("FAIL rand_out[%0d]: valid=%b data=%h dn=%h want valid=%b data=%h", n, out_valid, out_data, out_data_n, exp_valid(), exp_data());
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        sel = '0;
        out_ready = '0;
        mdl_clear();
        test_reset();
        test_routing();
        test_backpressure();
        test_independence();
        test_simul_drain();
`ifdef DEMUX_ROUND_ROBIN_EN
        test_round_robin();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
